mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/mem_arb_perf.sv | 24 ++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding, starvation default
// and the saturating-increment helper used by the optional perf counter.
package cpu_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WAIT_IF = 2'd1;
   localparam logic [1:0] ST_WAIT_D  = 2'd2;
   localparam logic [1:0] ST_RESP    = 2'd3;

   localparam int STARVE_LIMIT_DEF = 3;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      WAIT_IF = ST_WAIT_IF,
      WAIT_D  = ST_WAIT_D,
      RESP    = ST_RESP
   } arb_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/mem_arb_perf.sv
// Saturating 16-bit count of IDLE cycles in which fetch and data both request.
module mem_arb_perf
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [15:0] cnt
);

   logic [15:0] cnt_r;

   // Conflict counter, held at 16'hFFFF once it saturates.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r <= 16'd0;
      end else if (inc) begin
         cnt_r <= sat_inc16(cnt_r);
      end
   end

   assign cnt = cnt_r;

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single shared memory port, with fetch
// starvation protection. Define MEM_ARB_PERF_EN to add the conflict_cnt output.
module mem_arbiter
   import cpu_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_req,
   input  logic [WIDTH-1:0] if_addr,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [WIDTH-1:0] d_addr,
   input  logic [WIDTH-1:0] d_wdata,
   output logic             if_valid,
   output logic [WIDTH-1:0] if_rdata,
   output logic             d_valid,
   output logic [WIDTH-1:0] d_rdata,
   output logic             if_stall,
   output logic             d_stall,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic             mem_ready,
   input  logic [WIDTH-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [15:0]      conflict_cnt
`endif
);

   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

   arb_state_e       state_r;
   logic [CNT_W-1:0] starve_cnt_r;
   logic [WIDTH-1:0] cap_addr_r;
   logic [WIDTH-1:0] cap_wdata_r;
   logic             cap_we_r;
   logic             mem_req_r;
   logic             if_valid_r;
   logic             d_valid_r;
   logic [WIDTH-1:0] if_rdata_r;
   logic [WIDTH-1:0] d_rdata_r;

   logic             data_grant_s;
   logic             fetch_grant_s;

   // Data normally wins a tie; a fetch that has waited STARVE_LIMIT data grants goes first.
   assign data_grant_s  = d_req && !(if_req && (starve_cnt_r == LIMIT_C));
   assign fetch_grant_s = if_req && !data_grant_s;

   // Arbitration FSM; every output it owns is a register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= IDLE;
         starve_cnt_r <= {CNT_W{1'b0}};
         cap_addr_r   <= {WIDTH{1'b0}};
         cap_wdata_r  <= {WIDTH{1'b0}};
         cap_we_r     <= 1'b0;
         mem_req_r    <= 1'b0;
         if_valid_r   <= 1'b0;
         d_valid_r    <= 1'b0;
         if_rdata_r   <= {WIDTH{1'b0}};
         d_rdata_r    <= {WIDTH{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if_valid_r <= 1'b0;
               d_valid_r  <= 1'b0;
               if (data_grant_s) begin
                  cap_addr_r  <= d_addr;
                  cap_we_r    <= d_we;
                  cap_wdata_r <= d_wdata;
                  mem_req_r   <= 1'b1;
                  state_r     <= WAIT_D;
                  if (if_req && (starve_cnt_r != LIMIT_C)) begin
                     starve_cnt_r <= starve_cnt_r + CNT_W'(1);
                  end
               end else if (fetch_grant_s) begin
                  cap_addr_r   <= if_addr;
                  cap_we_r     <= 1'b0;
                  mem_req_r    <= 1'b1;
                  starve_cnt_r <= {CNT_W{1'b0}};
                  state_r      <= WAIT_IF;
               end
            end
            WAIT_IF: begin
               if (mem_ready) begin
                  if_rdata_r <= mem_rdata;
                  if_valid_r <= 1'b1;
                  mem_req_r  <= 1'b0;
                  state_r    <= RESP;
               end
            end
            WAIT_D: begin
               if (mem_ready) begin
                  // Stores complete with a pulse but leave d_rdata untouched.
                  if (!cap_we_r) begin
                     d_rdata_r <= mem_rdata;
                  end
                  d_valid_r <= 1'b1;
                  mem_req_r <= 1'b0;
                  state_r   <= RESP;
               end
            end
            RESP: begin
               if_valid_r <= 1'b0;
               d_valid_r  <= 1'b0;
               state_r    <= IDLE;
            end
            default: begin
               mem_req_r  <= 1'b0;
               if_valid_r <= 1'b0;
               d_valid_r  <= 1'b0;
               state_r    <= IDLE;
            end
         endcase
      end
   end

   assign mem_req   = mem_req_r;
   assign mem_we    = cap_we_r;
   assign mem_addr  = cap_addr_r;
   assign mem_wdata = cap_wdata_r;
   assign if_valid  = if_valid_r;
   assign d_valid   = d_valid_r;
   assign if_rdata  = if_rdata_r;
   assign d_rdata   = d_rdata_r;
   assign if_stall  = if_req & ~if_valid_r;
   assign d_stall   = d_req & ~d_valid_r;

`ifdef MEM_ARB_PERF_EN
   logic conflict_s;

   assign conflict_s = (state_r == IDLE) && if_req && d_req;

   mem_arb_perf u_perf (
      .clk (clk),
      .rst (rst),
      .inc (conflict_s),
      .cnt (conflict_cnt)
   );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner cases and
// random traffic against a transaction-level reference model.
module tb_mem_arbiter;

   localparam int W   = 32;
   localparam int LIM = 3;

   logic         clk;
   logic         rst;
   logic         if_req, d_req, d_we, mem_ready;
   logic [W-1:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic         if_valid, d_valid, if_stall, d_stall, mem_req, mem_we;
   logic [W-1:0] if_rdata, d_rdata, mem_addr, mem_wdata;
`ifdef MEM_ARB_PERF_EN
   logic [15:0]  conflict_cnt;
`endif

   int n_cmp;
   int n_bad;

   // Reference model: the transaction in flight plus the response cycle.
   bit           m_busy, m_resp, m_fetch, m_we;
   logic [W-1:0] m_addr, m_wdata, m_ifr, m_dr;
   int           m_starve, m_conf;

   typedef struct {
      logic         ifq, dq, we;
      logic [W-1:0] ia, da, wd, rd;
      logic         e_fetch;
      logic [W-1:0] e_addr;
      logic         e_we;
      logic [W-1:0] e_rdata;
   } vec_t;

   vec_t tbl [7];

   mem_arbiter #(.WIDTH(W), .STARVE_LIMIT(LIM)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .if_valid  (if_valid),
      .if_rdata  (if_rdata),
      .d_valid   (d_valid),
      .d_rdata   (d_rdata),
      .if_stall  (if_stall),
      .d_stall   (d_stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata)
`ifdef MEM_ARB_PERF_EN
      ,
      .conflict_cnt (conflict_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0; m_resp = 1'b0; m_fetch = 1'b0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_ifr = '0; m_dr = '0;
      m_starve = 0; m_conf = 0;
   endtask

   task automatic model_advance();
      if (!rst) begin
         model_reset();
      end else if (m_resp) begin
         m_resp = 1'b0;
      end else if (m_busy) begin
         if (mem_ready) begin
            m_busy = 1'b0;
            m_resp = 1'b1;
            if (m_fetch) m_ifr = mem_rdata;
            else if (!m_we) m_dr = mem_rdata;
         end
      end else begin
         if (if_req && d_req && m_conf < 65535) m_conf++;
         if (d_req && !(if_req && m_starve == LIM)) begin
            m_busy = 1'b1; m_fetch = 1'b0;
            m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
            if (if_req && m_starve < LIM) m_starve++;
         end else if (if_req) begin
            m_busy = 1'b1; m_fetch = 1'b1;
            m_addr = if_addr; m_we = 1'b0;
            m_starve = 0;
         end
      end
   endtask

   // One clock: compare against the model at the falling edge, advance it, resume just after the rising edge.
   task automatic step();
      @(negedge clk);
      chk1("m_mem_req", mem_req, m_busy);
      if (m_busy) begin
         chkw("m_mem_addr", mem_addr, m_addr);
         chk1("m_mem_we", mem_we, m_we);
         if (m_we) chkw("m_mem_wdata", mem_wdata, m_wdata);
      end
      chk1("m_if_valid", if_valid, m_resp && m_fetch);
      chk1("m_d_valid", d_valid, m_resp && !m_fetch);
      chkw("m_if_rdata", if_rdata, m_ifr);
      chkw("m_d_rdata", d_rdata, m_dr);
      chk1("m_if_stall", if_stall, if_req && !(m_resp && m_fetch));
      chk1("m_d_stall", d_stall, d_req && !(m_resp && !m_fetch));
`ifdef MEM_ARB_PERF_EN
      chkw("m_conflict_cnt", {16'd0, conflict_cnt}, m_conf);
`endif
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
   endtask

   initial begin
      int      hi;
      int      ng;
      logic    prev;
      logic    gfetch [8];

      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b0;
      quiet();
      model_reset();

      // Reset values, and no grant while reset is held even with requests up.
      repeat (2) @(posedge clk);
      #1;
      chk1("rst_mem_req", mem_req, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chkw("rst_mem_addr", mem_addr, 32'h0);
      chk1("rst_if_valid", if_valid, 1'b0);
      chk1("rst_d_valid", d_valid, 1'b0);
      chkw("rst_if_rdata", if_rdata, 32'h0);
      chkw("rst_d_rdata", d_rdata, 32'h0);
      if_req = 1'b1; d_req = 1'b1;
      @(posedge clk);
      #1;
      chk1("rst_hold_mem_req", mem_req, 1'b0);
      chk1("rst_if_stall", if_stall, 1'b1);
      quiet();
      rst = 1'b1;
      step();

      // Single-transaction vectors from IDLE.
      tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h4,  32'h0,  32'h0,        32'hDEADBEEF, 1'b1, 32'h4,   1'b0, 32'hDEADBEEF};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h0,  32'h40, 32'h0,        32'h12345678, 1'b0, 32'h40,  1'b0, 32'h12345678};
      tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h0,  32'h44, 32'hA5A5A5A5, 32'hFFFF0000, 1'b0, 32'h44,  1'b1, 32'h12345678};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h90, 32'h80, 32'h0,        32'h0BADF00D, 1'b0, 32'h80,  1'b0, 32'h0BADF00D};
      tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h94, 32'h84, 32'h77,       32'h11111111, 1'b0, 32'h84,  1'b1, 32'h0BADF00D};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h100,32'h0,  32'h0,        32'hCAFEF00D, 1'b1, 32'h100, 1'b0, 32'hCAFEF00D};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h104,32'h88, 32'h0,        32'h600DD00D, 1'b0, 32'h88,  1'b0, 32'h600DD00D};

      for (int i = 0; i < 7; i++) begin
         if_req = tbl[i].ifq; d_req = tbl[i].dq; d_we = tbl[i].we;
         if_addr = tbl[i].ia; d_addr = tbl[i].da; d_wdata = tbl[i].wd;
         mem_ready = 1'b0; mem_rdata = tbl[i].rd;
         step();
         chk1($sformatf("t%0d_mem_req", i), mem_req, 1'b1);
         chkw($sformatf("t%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
         chk1($sformatf("t%0d_mem_we", i), mem_we, tbl[i].e_we);
         if (tbl[i].e_we) chkw($sformatf("t%0d_mem_wdata", i), mem_wdata, tbl[i].wd);
         mem_ready = 1'b1;
         step();
         chk1($sformatf("t%0d_if_valid", i), if_valid, tbl[i].e_fetch);
         chk1($sformatf("t%0d_d_valid", i), d_valid, !tbl[i].e_fetch);
         if (tbl[i].e_fetch) chkw($sformatf("t%0d_if_rdata", i), if_rdata, tbl[i].e_rdata);
         else chkw($sformatf("t%0d_d_rdata", i), d_rdata, tbl[i].e_rdata);
         if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
         step();
         chk1($sformatf("t%0d_after_req", i), mem_req, 1'b0);
         chk1($sformatf("t%0d_after_valid", i), if_valid | d_valid, 1'b0);
      end

      // Simultaneous store and fetch: store first, fetch stalled until its own completion.
      if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_we = 1'b1;
      d_addr = 32'h10; d_wdata = 32'h55; mem_ready = 1'b0;
      step();
      chk1("both_mem_we", mem_we, 1'b1);
      chkw("both_mem_addr", mem_addr, 32'h10);
      chkw("both_mem_wdata", mem_wdata, 32'h55);
      chk1("both_if_stall_w", if_stall, 1'b1);
      mem_ready = 1'b1; mem_rdata = 32'h99;
      step();
      chk1("both_d_valid", d_valid, 1'b1);
      chk1("both_if_stall_r", if_stall, 1'b1);
      d_req = 1'b0; mem_ready = 1'b0;
      step();
      chk1("both_if_stall_i", if_stall, 1'b1);
      step();
      chk1("both_f_mem_we", mem_we, 1'b0);
      chkw("both_f_addr", mem_addr, 32'h200);
      chk1("both_if_stall_f", if_stall, 1'b1);
      mem_ready = 1'b1; mem_rdata = 32'h3C3C3C3C;
      step();
      chk1("both_if_valid", if_valid, 1'b1);
      chk1("both_if_stall_done", if_stall, 1'b0);
      chkw("both_if_rdata", if_rdata, 32'h3C3C3C3C);
      quiet();
      step();

      // Long wait: ready low for 5 wait cycles, address must not follow the input.
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
      step();
      hi = 0;
      for (int k = 0; k < 5; k++) begin
         if (mem_req) hi++;
         chkw("wait_addr", mem_addr, 32'h20);
         chk1("wait_d_stall", d_stall, 1'b1);
         d_addr = $urandom;
         step();
      end
      if (mem_req) hi++;
      chkw("wait_addr_last", mem_addr, 32'h20);
      mem_ready = 1'b1; mem_rdata = 32'h5A5A0000;
      step();
      chk1("wait_done_req", mem_req, 1'b0);
      chk1("wait_d_valid", d_valid, 1'b1);
      chkw("wait_req_cycles", hi, 32'd6);
      quiet();
      step();

      // Reset in the 2nd cycle of a fetch wait: abort with no pulse, then serve normally.
      if_req = 1'b1; if_addr = 32'h300;
      step();
      step();
      #1;
      rst = 1'b0;
      model_reset();
      #1;
      chk1("abort_mem_req", mem_req, 1'b0);
      chk1("abort_if_valid", if_valid, 1'b0);
      step();
      chk1("abort_if_valid_2", if_valid, 1'b0);
      rst = 1'b1;
      step();
      chk1("rearb_mem_req", mem_req, 1'b1);
      chkw("rearb_mem_addr", mem_addr, 32'h300);
      mem_ready = 1'b1; mem_rdata = 32'h0F0F0F0F;
      step();
      chk1("rearb_if_valid", if_valid, 1'b1);
      chkw("rearb_if_rdata", if_rdata, 32'h0F0F0F0F);
      quiet();
      step();

      // Both requests held from a fresh reset: grant order follows the starvation rule.
      rst = 1'b0;
      model_reset();
      step();
      rst = 1'b1;
      if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100;
      mem_ready = 1'b1;
      ng = 0;
      prev = 1'b0;
      for (int c = 0; c < 40 && ng < 8; c++) begin
         mem_rdata = $urandom;
         step();
         if (mem_req && !prev) begin
            gfetch[ng] = (mem_addr == 32'h200);
            ng++;
`ifdef MEM_ARB_PERF_EN
            if (ng == 4) chkw("conflict_cnt_4", {16'd0, conflict_cnt}, 32'd4);
`endif
         end
         prev = mem_req;
      end
      chkw("order_grants", ng, 32'd8);
      for (int g = 0; g < ng; g++) begin
         chk1($sformatf("order_g%0d_is_fetch", g), gfetch[g], (g % (LIM + 1)) == LIM);
      end
      quiet();
      step();
      step();

      // Random traffic, including requests dropped at any time and rare resets.
      for (int r = 0; r < 500; r++) begin
         if ($urandom_range(0, 99) == 0) begin
            rst = 1'b0;
            model_reset();
         end else begin
            rst = 1'b1;
         end
         if_req    = ($urandom_range(0, 9) < 6);
         d_req     = ($urandom_range(0, 9) < 6);
         d_we      = $urandom_range(0, 1);
         if_addr   = $urandom;
         d_addr    = $urandom;
         d_wdata   = $urandom;
         mem_ready = ($urandom_range(0, 2) != 0);
         mem_rdata = $urandom;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
